// File: rtl/sdram_arbiter.sv
// Two-port round-robin request arbiter in front of sdram_controller.
// One command in flight at a time; read data is routed back to the issuing port.
module sdram_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rdata_valid,
  input  logic              p1_req,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rdata_valid,
  output logic              busy,
  output logic              rw,
  output logic              rw_en,
  output logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f2s_data,
  input  logic              ready,
  input  logic [DATA_W-1:0] s2f_data,
  input  logic              s2f_data_valid
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_READ = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                rw_q, rw_d;
  logic                rw_en_q, rw_en_d;
  logic [ADDR_W-1:0]   f_addr_q, f_addr_d;
  logic [DATA_W-1:0]   f2s_data_q, f2s_data_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic                p0_rvalid_q, p0_rvalid_d;
  logic                p1_rvalid_q, p1_rvalid_d;
  logic                any_req_s;
  logic                grant_s;
  logic                accept_s;

  // Round-robin pick: on contention the port opposite the last grant wins.
  always_comb begin
    any_req_s = p0_req | p1_req;
    grant_s   = 1'b0;
    if (p0_req && p1_req) begin
      grant_s = ~last_grant_q;
    end else if (p1_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s = (state_q == ISSUE) & ready;

  // Next-state and command/return-path register updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    rw_d         = rw_q;
    rw_en_d      = rw_en_q;
    f_addr_d     = f_addr_q;
    f2s_data_d   = f2s_data_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    p0_rvalid_d  = 1'b0;
    p1_rvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          rw_d         = grant_s ? p1_rw    : p0_rw;
          f_addr_d     = grant_s ? p1_addr  : p0_addr;
          f2s_data_d   = grant_s ? p1_wdata : p0_wdata;
          rw_en_d      = 1'b1;
          last_grant_d = grant_s;
          owner_d      = grant_s;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (ready) begin
          rw_en_d = 1'b0;
          state_d = rw_q ? WAIT_READ : IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_READ: begin
        if (s2f_data_valid) begin
          if (owner_q) begin
            p1_rdata_d  = s2f_data;
            p1_rvalid_d = 1'b1;
          end else begin
            p0_rdata_d  = s2f_data;
            p0_rvalid_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          state_d = WAIT_READ;
        end
      end
      default: begin
        state_d = IDLE;
        rw_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any command without ack or data return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rw_q         <= 1'b0;
      rw_en_q      <= 1'b0;
      f_addr_q     <= {ADDR_W{1'b0}};
      f2s_data_q   <= {DATA_W{1'b0}};
      p0_rdata_q   <= {DATA_W{1'b0}};
      p1_rdata_q   <= {DATA_W{1'b0}};
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      rw_q         <= rw_d;
      rw_en_q      <= rw_en_d;
      f_addr_q     <= f_addr_d;
      f2s_data_q   <= f2s_data_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
    end
  end

  assign p0_ack         = accept_s & ~owner_q;
  assign p1_ack         = accept_s & owner_q;
  assign busy           = (state_q != IDLE);
  assign rw             = rw_q;
  assign rw_en          = rw_en_q;
  assign f_addr         = f_addr_q;
  assign f2s_data       = f2s_data_q;
  assign p0_rdata       = p0_rdata_q;
  assign p1_rdata       = p1_rdata_q;
  assign p0_rdata_valid = p0_rvalid_q;
  assign p1_rdata_valid = p1_rvalid_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, write hold, read routing,
// round-robin order, long ready stall and reset during a pending read.
module tb_sdram_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              p0_req, p1_req, p0_rw, p1_rw;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_ack, p1_ack;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              p0_rdata_valid, p1_rdata_valid;
  logic              busy, rw, rw_en;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f2s_data;
  logic              ready;
  logic [DATA_W-1:0] s2f_data;
  logic              s2f_data_valid;

  int n_vec = 0;
  int n_err = 0;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rdata_valid(p0_rdata_valid),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rdata_valid(p1_rdata_valid),
    .busy(busy), .rw(rw), .rw_en(rw_en), .f_addr(f_addr), .f2s_data(f2s_data),
    .ready(ready), .s2f_data(s2f_data), .s2f_data_valid(s2f_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 24'h000001; p0_wdata = 16'h1111;
    p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 24'h000002; p1_wdata = 16'h2222;
    ready = 1'b1; s2f_data = 16'h0000; s2f_data_valid = 1'b0;

    // Reset with both ports requesting and ready high
    repeat (5) cyc();
    mid();
    check_eq("rst_rw_en", 32'(rw_en), 32'd0);
    check_eq("rst_f_addr", 32'(f_addr), 32'd0);
    check_eq("rst_p0_ack", 32'(p0_ack), 32'd0);
    check_eq("rst_p1_ack", 32'(p1_ack), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rdata", {p0_rdata, p1_rdata}, 32'd0);
    cyc();
    rst_n = 1'b1; ready = 1'b0;
    mid();
    check_eq("rel_rw_en_low", 32'(rw_en), 32'd0);
    cyc();
    mid();
    check_eq("rel_rw_en_high", 32'(rw_en), 32'd1);
    check_eq("rel_p0_first", 32'(f_addr), 32'h000001);
    check_eq("rel_p0_wdata", 32'(f2s_data), 32'h1111);
    check_eq("rel_busy", 32'(busy), 32'd1);
    check_eq("rel_no_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
    cyc();
    ready = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
    mid();
    check_eq("rel_acks", {30'd0, p1_ack, p0_ack}, 32'd1);
    cyc();
    ready = 1'b0;
    mid();
    check_eq("rel_idle_rw_en", 32'(rw_en), 32'd0);
    check_eq("rel_idle_busy", 32'(busy), 32'd0);

    // Single p0 write, ready low for 4 cycles, inputs changed after grant
    cyc();
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 24'h000A05; p0_wdata = 16'hBEEF;
    cyc();
    p0_addr = 24'hFFFFFF; p0_wdata = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      mid();
      check_eq("wr_rw_en", 32'(rw_en), 32'd1);
      check_eq("wr_f_addr", 32'(f_addr), 32'h000A05);
      check_eq("wr_f2s_data", 32'(f2s_data), 32'hBEEF);
      check_eq("wr_rw", 32'(rw), 32'd0);
      check_eq("wr_no_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
      cyc();
    end
    ready = 1'b1; p0_req = 1'b0;
    mid();
    check_eq("wr_ack", {30'd0, p1_ack, p0_ack}, 32'd1);
    cyc();
    mid();
    check_eq("wr_ack_once", {30'd0, p1_ack, p0_ack}, 32'd0);
    check_eq("wr_idle", {30'd0, busy, rw_en}, 32'd0);
    cyc();
    ready = 1'b0;

    // p1 read of 0x123456, data returned 5 cycles after acceptance
    p1_req = 1'b1; p1_rw = 1'b1; p1_addr = 24'h123456;
    cyc();
    ready = 1'b1;
    mid();
    check_eq("rd_cmd", {7'd0, rw, f_addr}, {8'h01, 24'h123456});
    check_eq("rd_ack", {30'd0, p1_ack, p0_ack}, 32'd2);
    cyc();
    ready = 1'b0; p1_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check_eq("rd_wait_busy", {30'd0, busy, p1_rdata_valid}, 32'd2);
      check_eq("rd_wait_rw_en", 32'(rw_en), 32'd0);
      cyc();
    end
    s2f_data = 16'h55AA; s2f_data_valid = 1'b1;
    mid();
    check_eq("rd_valid_not_yet", 32'(p1_rdata_valid), 32'd0);
    cyc();
    s2f_data = 16'h0000; s2f_data_valid = 1'b0;
    mid();
    check_eq("rd_p1_rdata", 32'(p1_rdata), 32'h55AA);
    check_eq("rd_p1_valid", 32'(p1_rdata_valid), 32'd1);
    check_eq("rd_p0_valid", 32'(p0_rdata_valid), 32'd0);
    check_eq("rd_p0_rdata", 32'(p0_rdata), 32'd0);
    check_eq("rd_busy", 32'(busy), 32'd0);
    cyc();
    mid();
    check_eq("rd_valid_pulse", 32'(p1_rdata_valid), 32'd0);
    check_eq("rd_rdata_hold", 32'(p1_rdata), 32'h55AA);

    // Round-robin: both ports writing back-to-back, ready high
    cyc();
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 24'h000100; p0_wdata = 16'hA000;
    p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 24'h000200; p1_wdata = 16'hB000;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      mid();
      check_eq("rr_f_addr", 32'(f_addr), (i % 2 == 0) ? 32'h000100 : 32'h000200);
      check_eq("rr_ack", {30'd0, p1_ack, p0_ack}, (i % 2 == 0) ? 32'd1 : 32'd2);
      cyc();
      mid();
      check_eq("rr_gap", {29'd0, busy, p1_ack, p0_ack}, 32'd0);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    ready = 1'b0;

    // Refresh stall: ready low for 80 cycles in ISSUE
    cyc();
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 24'h000300; p0_wdata = 16'h3333;
    cyc();
    for (int i = 0; i < 80; i++) begin
      mid();
      check_eq("stall_hold", {29'd0, rw_en, p1_ack, p0_ack}, 32'd4);
      cyc();
    end
    ready = 1'b1; p0_req = 1'b0;
    mid();
    check_eq("stall_ack", {30'd0, p1_ack, p0_ack}, 32'd1);
    check_eq("stall_f_addr", 32'(f_addr), 32'h000300);
    cyc();
    mid();
    check_eq("stall_no_dup", {29'd0, busy, p1_ack, p0_ack}, 32'd0);
    cyc();
    ready = 1'b0;

    // Reset while p0 read is waiting for data
    p0_req = 1'b1; p0_rw = 1'b1; p0_addr = 24'h000400;
    cyc();
    ready = 1'b1; p0_req = 1'b0;
    mid();
    check_eq("rwr_ack", {30'd0, p1_ack, p0_ack}, 32'd1);
    cyc();
    ready = 1'b0;
    mid();
    check_eq("rwr_wait", 32'(busy), 32'd1);
    cyc();
    rst_n = 1'b0;
    mid();
    check_eq("rwr_busy", 32'(busy), 32'd0);
    check_eq("rwr_cmd", {7'd0, rw_en, f_addr}, 32'd0);
    check_eq("rwr_valid", {30'd0, p1_rdata_valid, p0_rdata_valid}, 32'd0);
    cyc();
    rst_n = 1'b1; s2f_data = 16'h7777; s2f_data_valid = 1'b1;
    mid();
    check_eq("late_valid_a", {30'd0, p1_rdata_valid, p0_rdata_valid}, 32'd0);
    cyc();
    s2f_data_valid = 1'b0; s2f_data = 16'h0000;
    mid();
    check_eq("late_valid_b", {30'd0, p1_rdata_valid, p0_rdata_valid}, 32'd0);
    check_eq("late_rdata", {p0_rdata, p1_rdata}, 32'd0);
    check_eq("late_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
